mc_cu_hs: RTL and testbench
===========================

// Module: mc_cu_hs
// PURPOSE
//  Parametrised multi-cycle control unit for the RV32 multi-cycle core; successor to the fixed-latency cu.
//  Adds ready-based instruction/data memory handshakes (wait states), full branch set (BEQ..BGEU),
//  wait-state timeout with sticky trap, and a retired-instruction counter. Drives PC/PC0/IR/regfile/DM strobes.
// PARAMETERS
//  OPW      4      width of ALU_OP / ALU_OP_o
//  ALU_ADD  4'h0   ALU code forced for LW/SW/JALR address add
//  ALU_SUB  4'h8   ALU code forced for branch compare
//  BR_EXT   1      1: BNE/BLT/BGE/BLTU/BGEU legal; 0: only BEQ, other funct3 -> trap
//  TO_W     8      timeout counter width
//  TIMEOUT  200    max wait cycles per handshake; 0 disables timeout
//  CNT_W    32     instret counter width
// PORTS
//  clk        in   1     core clock, all state on rising edge
//  rst        in   1     synchronous active-high reset
//  IS_R,IS_IMM,IS_LUI,IS_LW,IS_SW,IS_BEQ,IS_JALR,IS_JAL  in 1 each  decoded class (IS_BEQ = any branch opcode)
//  funct3     in   3     branch type
//  ALU_OP     in   OPW   decoded ALU op for R/IMM
//  ZF,SF,OF,CF in  1     registered ALU flags (valid in S_BR); CF=1 means unsigned A<B
//  imem_ready in   1     instruction word valid this cycle
//  dmem_ready in   1     data access complete this cycle
//  imem_req   out  1     fetch request
//  dmem_req   out  1     data access request
//  PC_Write,PC0_Write,IR_Write,Reg_Write,Mem_Write  out 1  datapath strobes
//  rs2_imm_s  out  1     1: ALU B = imm32
//  w_data_s   out  2     00 ALU F, 01 imm32, 10 MDR, 11 PC+4
//  PC_s       out  2     00 PC+4, 01 PC0+imm32, 10 ALU F
//  ALU_OP_o   out  OPW   ALU op to datapath
//  trap       out  1     sticky: illegal instruction or timeout
//  bus_err    out  1     sticky: trap caused by timeout
//  instret    out  CNT_W retired instruction count
// BEHAVIOUR
//  States: S_IF, S_ID, S_EX, S_MEM, S_BR, S_WB, S_TRAP; strobes are Moore/Mealy decode of state+inputs.
//  Reset: state=S_IF, wait cnt=0, instret=0, trap=bus_err=0; all outputs 0 while rst=1.
//  S_IF: imem_req=1. imem_ready=1 -> IR_Write=PC_Write=PC0_Write=1, PC_s=00, -> S_ID; else stay.
//  S_ID: no strobes. No IS_* set, or branch with illegal funct3 (010/011 always; non-000 if BR_EXT=0) -> S_TRAP.
//   LUI/JAL -> S_WB; all others -> S_EX.
//  S_EX: ALU_OP_o=ALU_OP (R/IMM), ALU_ADD (LW/SW/JALR), ALU_SUB (branch); rs2_imm_s=1 for IMM/LW/SW/JALR.
//   R/IMM/JALR -> S_WB; LW/SW -> S_MEM; branch -> S_BR.
//  S_MEM: dmem_req=1, Mem_Write=IS_SW held until dmem_ready. dmem_ready: SW -> S_IF (retire), LW -> S_WB.
//  S_BR: taken = 000 ZF | 001 !ZF | 100 SF^OF | 101 !(SF^OF) | 110 CF | 111 !CF.
//   taken -> PC_s=01, PC_Write=1. Always -> S_IF, retire.
//  S_WB: Reg_Write=1; w_data_s 00 R/IMM, 01 LUI, 10 LW, 11 JAL/JALR. JAL: PC_s=01,PC_Write=1;
//   JALR: PC_s=10,PC_Write=1. -> S_IF, retire.
//  S_TRAP: all strobes/reqs 0, trap=1; only rst exits.
//  ALU_OP_o = ALU_OP outside S_EX (holds ALU code stable for result register).
//  Latency (zero wait): R/IMM/JALR 4 cyc, LUI/JAL 3, SW 4, LW 5, branch 4; +1 per wait cycle.
//  Wait counter: counts consecutive cycles in S_IF/S_MEM with ready=0; clears on state change.
//   TIMEOUT!=0 and count reaches TIMEOUT-1 with ready still 0 -> S_TRAP, bus_err=1 next cycle.
//   ready=1 on the same cycle as limit: handshake wins, no trap.
//  Retire: instret+=1 on the cycle leaving S_WB/S_BR/S_MEM(SW); wraps modulo 2^CNT_W.
//  rst asserted mid-wait or mid-write: next edge forces reset state; in-flight access abandoned.
// TESTING
//  ADD x3,x1,x2 with imem_ready=1 -> states IF,ID,EX,WB; Reg_Write=1 w_data_s=00 in cycle 4; instret=1.
//  LW with dmem_ready low 3 cycles -> dmem_req held 4 cycles, then WB with w_data_s=10; total 8 cycles.
//  BNE, ZF=0 -> S_BR PC_s=01 PC_Write=1; ZF=1 -> PC_Write=0; BLTU CF=1 taken; BR_EXT=0 BNE -> trap=1.
//  JALR -> WB Reg_Write=1 w_data_s=11 PC_s=10 PC_Write=1; JAL skips S_EX (3 cycles), PC_s=01.
//  TIMEOUT=4, imem_ready=0 forever -> trap=bus_err=1 after 4 S_IF cycles; stays until rst.
//  All IS_*=0 -> S_TRAP from S_ID, bus_err=0; rst=1 in S_MEM with Mem_Write=1 -> next cycle S_IF, strobes 0.

Source files
------------

// File: rtl/mc_cu_hs_if.sv
// Handshake/control bundle between the multi-cycle control unit and its datapath.
// master: control unit side (consumes decode/flags/ready, drives strobes/requests/status).
// slave : datapath/memory side (the mirror image).
// Signals:
//   IS_R..IS_JAL   decoded instruction class (IS_BEQ = any branch opcode)
//   funct3         branch type
//   ALU_OP         decoded ALU op for R/IMM
//   ZF,SF,OF,CF    registered ALU flags
//   imem_ready     instruction word valid this cycle
//   dmem_ready     data access complete this cycle
//   imem_req       fetch request
//   dmem_req       data access request
//   PC_Write,PC0_Write,IR_Write,Reg_Write,Mem_Write  datapath strobes
//   rs2_imm_s      ALU B select (1: imm32)
//   w_data_s       register write-back select
//   PC_s           next-PC select
//   ALU_OP_o       ALU op to datapath
//   trap,bus_err   sticky status
//   instret        retired instruction count
interface mc_cu_hs_if #(
    parameter int unsigned OPW   = 4,
    parameter int unsigned CNT_W = 32
);
    logic             IS_R, IS_IMM, IS_LUI, IS_LW, IS_SW, IS_BEQ, IS_JALR, IS_JAL;
    logic [2:0]       funct3;
    logic [OPW-1:0]   ALU_OP;
    logic             ZF, SF, OF, CF;
    logic             imem_ready, dmem_ready;
    logic             imem_req, dmem_req;
    logic             PC_Write, PC0_Write, IR_Write, Reg_Write, Mem_Write;
    logic             rs2_imm_s;
    logic [1:0]       w_data_s, PC_s;
    logic [OPW-1:0]   ALU_OP_o;
    logic             trap, bus_err;
    logic [CNT_W-1:0] instret;

    modport master (
        input  IS_R, IS_IMM, IS_LUI, IS_LW, IS_SW, IS_BEQ, IS_JALR, IS_JAL,
        input  funct3, ALU_OP, ZF, SF, OF, CF, imem_ready, dmem_ready,
        output imem_req, dmem_req, PC_Write, PC0_Write, IR_Write, Reg_Write, Mem_Write,
        output rs2_imm_s, w_data_s, PC_s, ALU_OP_o, trap, bus_err, instret
    );

    modport slave (
        output IS_R, IS_IMM, IS_LUI, IS_LW, IS_SW, IS_BEQ, IS_JALR, IS_JAL,
        output funct3, ALU_OP, ZF, SF, OF, CF, imem_ready, dmem_ready,
        input  imem_req, dmem_req, PC_Write, PC0_Write, IR_Write, Reg_Write, Mem_Write,
        input  rs2_imm_s, w_data_s, PC_s, ALU_OP_o, trap, bus_err, instret
    );
endinterface

// File: rtl/mc_cu_hs.sv
// Multi-cycle control unit for the RV32 multi-cycle core with ready-based memory handshakes,
// full branch set, wait-state timeout (sticky trap) and a retired-instruction counter.
// Ports:
//   clk  core clock, all state on the rising edge
//   rst  synchronous active-high reset; all outputs forced to 0 while asserted
//   bus  mc_cu_hs_if.master: decode/flags/ready in, strobes/requests/status out
module mc_cu_hs #(
    parameter int unsigned    OPW     = 4,
    parameter logic [OPW-1:0] ALU_ADD = OPW'(0),
    parameter logic [OPW-1:0] ALU_SUB = OPW'(8),
    parameter bit             BR_EXT  = 1'b1,
    parameter int unsigned    TO_W    = 8,
    parameter int unsigned    TIMEOUT = 200,
    parameter int unsigned    CNT_W   = 32
) (
    input  logic         clk,
    input  logic         rst,
    mc_cu_hs_if.master   bus
);

    typedef enum logic [2:0] {StIf, StId, StEx, StMem, StBr, StWb, StTrap} state_e;

    state_e           state_q, state_d;
    logic [TO_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0] instret_q;
    logic             trap_q, bus_err_q;

    logic is_mem, any_class, br_illegal, taken, waiting, timeout, retire;

    logic           imem_req, dmem_req, pc_write, pc0_write, ir_write, reg_write, mem_write;
    logic           rs2_imm_s;
    logic [1:0]     w_data_s, pc_s;
    logic [OPW-1:0] alu_op_drv;

    assign is_mem    = bus.IS_LW | bus.IS_SW;
    assign any_class = |{bus.IS_R, bus.IS_IMM, bus.IS_LUI, bus.IS_LW, bus.IS_SW, bus.IS_BEQ,
                         bus.IS_JALR, bus.IS_JAL};
    // 010/011 are never branches; without extended branches only BEQ is legal
    assign br_illegal = (bus.funct3[2:1] == 2'b01) || (!BR_EXT && (bus.funct3 != 3'b000));

    always_comb begin
        case (bus.funct3)
            3'b000:  taken = bus.ZF;
            3'b001:  taken = !bus.ZF;
            3'b100:  taken = bus.SF ^ bus.OF;
            3'b101:  taken = !(bus.SF ^ bus.OF);
            3'b110:  taken = bus.CF;
            3'b111:  taken = !bus.CF;
            default: taken = 1'b0;
        endcase
    end

    assign waiting = ((state_q == StIf) && !bus.imem_ready) ||
                     ((state_q == StMem) && !bus.dmem_ready);
    // ready on the limit cycle suppresses the timeout since waiting is then 0
    assign timeout = (TIMEOUT != 0) && waiting && (wait_q == TO_W'(TIMEOUT - 1));
    assign wait_d  = waiting ? wait_q + TO_W'(1) : '0;

    assign retire = (state_q == StWb) || (state_q == StBr) ||
                    ((state_q == StMem) && bus.dmem_ready && bus.IS_SW);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIf;
            wait_q    <= '0;
            instret_q <= '0;
            trap_q    <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (retire)           instret_q <= instret_q + CNT_W'(1);
            if (state_d == StTrap) trap_q   <= 1'b1;
            if (timeout)          bus_err_q <= 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIf: begin
                if (timeout)             state_d = StTrap;
                else if (bus.imem_ready) state_d = StId;
            end
            StId: begin
                if (!any_class || (bus.IS_BEQ && br_illegal)) state_d = StTrap;
                else if (bus.IS_LUI || bus.IS_JAL)            state_d = StWb;
                else                                          state_d = StEx;
            end
            StEx: begin
                if (is_mem)          state_d = StMem;
                else if (bus.IS_BEQ) state_d = StBr;
                else                 state_d = StWb;
            end
            StMem: begin
                if (timeout)             state_d = StTrap;
                else if (bus.dmem_ready) state_d = bus.IS_SW ? StIf : StWb;
            end
            StBr, StWb: state_d = StIf;
            StTrap:     state_d = StTrap;
            default:    state_d = StIf;
        endcase
    end

    // Output decode
    always_comb begin
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        pc_write   = 1'b0;
        pc0_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        rs2_imm_s  = 1'b0;
        w_data_s   = 2'b00;
        pc_s       = 2'b00;
        alu_op_drv = bus.ALU_OP;
        case (state_q)
            StIf: begin
                imem_req = 1'b1;
                if (bus.imem_ready) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    pc0_write = 1'b1;
                end
            end
            StEx: begin
                rs2_imm_s = bus.IS_IMM | is_mem | bus.IS_JALR;
                if (is_mem || bus.IS_JALR) alu_op_drv = ALU_ADD;
                else if (bus.IS_BEQ)       alu_op_drv = ALU_SUB;
            end
            StMem: begin
                dmem_req  = 1'b1;
                mem_write = bus.IS_SW;
            end
            StBr: begin
                if (taken) begin
                    pc_s     = 2'b01;
                    pc_write = 1'b1;
                end
            end
            StWb: begin
                reg_write = 1'b1;
                if (bus.IS_LW)                    w_data_s = 2'b10;
                else if (bus.IS_LUI)              w_data_s = 2'b01;
                else if (bus.IS_JAL || bus.IS_JALR) w_data_s = 2'b11;
                if (bus.IS_JAL) begin
                    pc_s     = 2'b01;
                    pc_write = 1'b1;
                end else if (bus.IS_JALR) begin
                    pc_s     = 2'b10;
                    pc_write = 1'b1;
                end
            end
            default: ;
        endcase
        if (rst) begin
            imem_req   = 1'b0;
            dmem_req   = 1'b0;
            pc_write   = 1'b0;
            pc0_write  = 1'b0;
            ir_write   = 1'b0;
            reg_write  = 1'b0;
            mem_write  = 1'b0;
            rs2_imm_s  = 1'b0;
            w_data_s   = 2'b00;
            pc_s       = 2'b00;
            alu_op_drv = '0;
        end
    end

    assign bus.imem_req  = imem_req;
    assign bus.dmem_req  = dmem_req;
    assign bus.PC_Write  = pc_write;
    assign bus.PC0_Write = pc0_write;
    assign bus.IR_Write  = ir_write;
    assign bus.Reg_Write = reg_write;
    assign bus.Mem_Write = mem_write;
    assign bus.rs2_imm_s = rs2_imm_s;
    assign bus.w_data_s  = w_data_s;
    assign bus.PC_s      = pc_s;
    assign bus.ALU_OP_o  = alu_op_drv;
    assign bus.trap      = trap_q & !rst;
    assign bus.bus_err   = bus_err_q & !rst;
    assign bus.instret   = rst ? '0 : instret_q;

endmodule

// File: tb/tb_mc_cu_hs.sv
// Self-checking bench for mc_cu_hs: random instruction stream with random wait states checked
// against an instruction-level model (latency, strobe counts, selects, instret), plus directed
// reset, illegal-instruction and timeout scenarios.
module tb_mc_cu_hs;

    localparam int K_R = 0, K_IMM = 1, K_LUI = 2, K_LW = 3, K_SW = 4, K_BR = 5, K_JALR = 6,
                   K_JAL = 7;
    localparam int TMO = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   compared = 0;
    int   mismatched = 0;
    int   model_instret = 0;

    always #5 clk = ~clk;

    mc_cu_hs_if #(.OPW(4), .CNT_W(32)) bus ();

    mc_cu_hs #(
        .OPW(4), .ALU_ADD(4'h0), .ALU_SUB(4'h8), .BR_EXT(1'b1),
        .TO_W(8), .TIMEOUT(TMO), .CNT_W(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_class(input int kind);
        bus.IS_R    = (kind == K_R);
        bus.IS_IMM  = (kind == K_IMM);
        bus.IS_LUI  = (kind == K_LUI);
        bus.IS_LW   = (kind == K_LW);
        bus.IS_SW   = (kind == K_SW);
        bus.IS_BEQ  = (kind == K_BR);
        bus.IS_JALR = (kind == K_JALR);
        bus.IS_JAL  = (kind == K_JAL);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_class(K_R);
        bus.imem_ready = 1'b1;
        bus.dmem_ready = 1'b1;
        @(negedge clk);
        check("rst_imem_req", 32'(bus.imem_req), 32'd0);
        check("rst_ir_write", 32'(bus.IR_Write), 32'd0);
        check("rst_trap", 32'(bus.trap), 32'd0);
        check("rst_instret", bus.instret, 32'd0);
        step();
        rst = 1'b0;
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        model_instret = 0;
    endtask

    // One instruction: fetch waits iw cycles, data access waits dw cycles; a,b are the
    // branch operands from which the flags are derived as an ALU subtraction would.
    task automatic run_instr(input int kind, input logic [2:0] f3, input int iw, input int dw,
                             input logic [31:0] a, input logic [31:0] b);
        logic [31:0] diff;
        logic [3:0]  op, exp_op;
        logic [1:0]  last_pcs, last_wd;
        logic        taken;
        bit          is_mem, has_ex, wr, uses_imm;
        int          lat, exp_pcw, exp_pcs, exp_wd;
        int          n_ireq, n_dreq, n_mw, n_pcw, n_rw, n_imm, n_ir, n_pc0;
        op = 4'($urandom);
        set_class(kind);
        bus.funct3 = f3;
        bus.ALU_OP = op;
        diff = a - b;
        bus.ZF = (diff == 32'd0);
        bus.CF = (a < b);
        bus.SF = diff[31];
        bus.OF = (a[31] != b[31]) && (diff[31] != a[31]);
        case (f3)
            3'b000:  taken = (a == b);
            3'b001:  taken = (a != b);
            3'b100:  taken = ($signed(a) < $signed(b));
            3'b101:  taken = ($signed(a) >= $signed(b));
            3'b110:  taken = (a < b);
            default: taken = (a >= b);
        endcase
        is_mem   = (kind == K_LW) || (kind == K_SW);
        has_ex   = !((kind == K_LUI) || (kind == K_JAL));
        wr       = !((kind == K_SW) || (kind == K_BR));
        uses_imm = (kind == K_IMM) || is_mem || (kind == K_JALR);
        case (kind)
            K_LUI, K_JAL: lat = 3;
            K_LW:         lat = 5;
            default:      lat = 4;
        endcase
        lat += iw + (is_mem ? dw : 0);
        exp_op = (is_mem || kind == K_JALR) ? 4'h0 : (kind == K_BR) ? 4'h8 : op;
        case (kind)
            K_JAL:   exp_pcs = 1;
            K_JALR:  exp_pcs = 2;
            K_BR:    exp_pcs = taken ? 1 : 0;
            default: exp_pcs = 0;
        endcase
        exp_pcw = 1 + ((exp_pcs != 0) ? 1 : 0);
        case (kind)
            K_LUI:        exp_wd = 1;
            K_LW:         exp_wd = 2;
            K_JAL, K_JALR: exp_wd = 3;
            default:      exp_wd = 0;
        endcase
        n_ireq = 0; n_dreq = 0; n_mw = 0; n_pcw = 0; n_rw = 0; n_imm = 0; n_ir = 0; n_pc0 = 0;
        last_pcs = 2'b00;
        last_wd  = 2'b00;
        for (int c = 0; c < lat; c++) begin
            bus.imem_ready = (c == iw);
            bus.dmem_ready = is_mem && (c == iw + 3 + dw);
            @(negedge clk);
            if (c == 0) begin
                check("fetch_start", 32'(bus.imem_req), 32'd1);
                check("alu_op_pass", 32'(bus.ALU_OP_o), 32'(op));
            end
            if (has_ex && c == iw + 2) check("ex_alu_op", 32'(bus.ALU_OP_o), 32'(exp_op));
            if (bus.imem_req)  n_ireq++;
            if (bus.dmem_req)  n_dreq++;
            if (bus.Mem_Write) n_mw++;
            if (bus.PC_Write)  n_pcw++;
            if (bus.Reg_Write) n_rw++;
            if (bus.rs2_imm_s) n_imm++;
            if (bus.IR_Write)  n_ir++;
            if (bus.PC0_Write) n_pc0++;
            last_pcs = bus.PC_s;
            last_wd  = bus.w_data_s;
            step();
        end
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        model_instret++;
        check("imem_req_cycles", n_ireq, iw + 1);
        check("dmem_req_cycles", n_dreq, is_mem ? dw + 1 : 0);
        check("mem_write_cycles", n_mw, (kind == K_SW) ? dw + 1 : 0);
        check("ir_write_cycles", n_ir, 1);
        check("pc0_write_cycles", n_pc0, 1);
        check("pc_write_cycles", n_pcw, exp_pcw);
        check("reg_write_cycles", n_rw, wr ? 1 : 0);
        check("rs2_imm_cycles", n_imm, uses_imm ? 1 : 0);
        check("final_pc_s", 32'(last_pcs), exp_pcs);
        if (wr) check("final_w_data_s", 32'(last_wd), exp_wd);
        check("instret", bus.instret, model_instret);
        check("no_trap", 32'(bus.trap), 32'd0);
    endtask

    initial begin
        logic [2:0] br_f3 [6];
        logic [31:0] a, b;
        br_f3[0] = 3'b000; br_f3[1] = 3'b001; br_f3[2] = 3'b100;
        br_f3[3] = 3'b101; br_f3[4] = 3'b110; br_f3[5] = 3'b111;
        set_class(K_R);
        bus.funct3 = 3'b000;
        bus.ALU_OP = 4'h0;
        bus.ZF = 1'b0; bus.SF = 1'b0; bus.OF = 1'b0; bus.CF = 1'b0;
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        do_reset();

        // Directed instructions
        run_instr(K_R,    3'b000, 0, 0, 32'd1, 32'd2);
        run_instr(K_LW,   3'b000, 0, 3, 32'd0, 32'd0);
        run_instr(K_BR,   3'b001, 0, 0, 32'd5, 32'd7);
        run_instr(K_BR,   3'b001, 0, 0, 32'd5, 32'd5);
        run_instr(K_BR,   3'b110, 0, 0, 32'd1, 32'd2);
        run_instr(K_BR,   3'b100, 1, 0, 32'hFFFF_FFFF, 32'd1);
        run_instr(K_JALR, 3'b000, 0, 0, 32'd0, 32'd0);
        run_instr(K_JAL,  3'b000, 0, 0, 32'd0, 32'd0);
        run_instr(K_LUI,  3'b000, 2, 0, 32'd0, 32'd0);
        // Ready arrives on the timeout limit cycle: handshake must win
        run_instr(K_SW,   3'b000, TMO - 1, TMO - 1, 32'd0, 32'd0);
        run_instr(K_LW,   3'b000, TMO - 1, TMO - 1, 32'd0, 32'd0);

        // Random instruction stream
        for (int n = 0; n < 60; n++) begin
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            if ($urandom_range(0, 3) == 0) b = {~a[31], a[30:0]};
            run_instr(int'($urandom_range(0, 7)), br_f3[$urandom_range(0, 5)],
                      int'($urandom_range(0, TMO - 1)), int'($urandom_range(0, TMO - 1)), a, b);
        end

        // Reset while a store is waiting in the data phase
        do_reset();
        set_class(K_SW);
        bus.imem_ready = 1'b1;
        @(negedge clk); step();
        bus.imem_ready = 1'b0;
        @(negedge clk); step();
        @(negedge clk); step();
        @(negedge clk);
        check("mem_wait_mem_write", 32'(bus.Mem_Write), 32'd1);
        check("mem_wait_dmem_req", 32'(bus.dmem_req), 32'd1);
        step();
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_mem_write", 32'(bus.Mem_Write), 32'd0);
        check("rst_mid_dmem_req", 32'(bus.dmem_req), 32'd0);
        step();
        rst = 1'b0;
        bus.dmem_ready = 1'b1;
        @(negedge clk);
        check("post_rst_fetch", 32'(bus.imem_req), 32'd1);
        check("post_rst_mem_write", 32'(bus.Mem_Write), 32'd0);
        check("post_rst_dmem_req", 32'(bus.dmem_req), 32'd0);
        check("post_rst_instret", bus.instret, 32'd0);
        step();

        // Illegal branch funct3 and empty decode both trap without bus_err
        for (int t = 0; t < 2; t++) begin
            do_reset();
            set_class((t == 0) ? K_BR : -1);
            bus.funct3 = 3'b010;
            bus.imem_ready = 1'b1;
            @(negedge clk); step();
            bus.imem_ready = 1'b0;
            @(negedge clk);
            check("id_no_trap_yet", 32'(bus.trap), 32'd0);
            step();
            for (int c = 0; c < 3; c++) begin
                bus.imem_ready = (c == 2);
                @(negedge clk);
                check("illegal_trap", 32'(bus.trap), 32'd1);
                check("illegal_bus_err", 32'(bus.bus_err), 32'd0);
                check("illegal_imem_req", 32'(bus.imem_req), 32'd0);
                check("illegal_pc_write", 32'(bus.PC_Write), 32'd0);
                step();
            end
        end

        // Fetch never completes: timeout after TMO fetch cycles, stuck until reset
        do_reset();
        set_class(K_R);
        bus.imem_ready = 1'b0;
        for (int c = 0; c < TMO; c++) begin
            @(negedge clk);
            check("tmo_fetch_req", 32'(bus.imem_req), 32'd1);
            check("tmo_not_yet", 32'(bus.trap), 32'd0);
            step();
        end
        for (int c = 0; c < 3; c++) begin
            bus.imem_ready = (c == 2);
            @(negedge clk);
            check("tmo_trap", 32'(bus.trap), 32'd1);
            check("tmo_bus_err", 32'(bus.bus_err), 32'd1);
            check("tmo_imem_req", 32'(bus.imem_req), 32'd0);
            check("tmo_ir_write", 32'(bus.IR_Write), 32'd0);
            step();
        end
        do_reset();
        bus.imem_ready = 1'b0;
        @(negedge clk);
        check("tmo_cleared_trap", 32'(bus.trap), 32'd0);
        check("tmo_cleared_bus_err", 32'(bus.bus_err), 32'd0);
        step();
        do_reset();
        run_instr(K_IMM, 3'b000, 1, 0, 32'd0, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
